// File: rtl/buffer.sv
// Four-line RGB565 line buffer presenting three vertically adjacent pixels per column.
// Optional macro BUFFER_OUT_ZERO_EN: line_buffer_out reads zero whenever data_valid_out is low.
module buffer #(
  parameter int HRES = 320,
  parameter int VRES = 240
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [10:0]      hcount_in,
  input  logic [9:0]       vcount_in,
  input  logic [15:0]      pixel_data_in,
  input  logic             data_valid_in,
  output logic [2:0][15:0] line_buffer_out,
  output logic [10:0]      hcount_out,
  output logic [9:0]       vcount_out,
  output logic             data_valid_out
);

  localparam int AW = (HRES > 1) ? $clog2(HRES) : 1;
  localparam logic [11:0] HLIM = 12'(HRES);
  localparam logic [10:0] VLIM = 11'(VRES);
  localparam logic [9:0]  VM2  = 10'(VRES - 2);

  logic [1:0]       wsel;
  logic             h_ok;
  logic             v_ok;
  logic             wr_en;
  logic [AW-1:0]    addr;
  logic [9:0]       vrow;
  logic [3:0][15:0] rd_data;

  assign wsel  = vcount_in[1:0];
  assign h_ok  = ({1'b0, hcount_in} < HLIM);
  assign v_ok  = ({1'b0, vcount_in} < VLIM);
  assign wr_en = data_valid_in && h_ok && v_ok;
  // Out-of-range columns are never valid; clamping keeps the RAM index legal.
  assign addr  = h_ok ? hcount_in[AW-1:0] : '0;

  always_comb begin
    vrow = vcount_in - 10'd2;
    if (vcount_in < 10'd2) vrow = vcount_in + VM2;
  end

  for (genvar k = 0; k < 4; k++) begin : g_ram
    logic [15:0] mem [HRES];
    logic [15:0] q;

    always_ff @(posedge clk_in) begin
      if (wr_en && (wsel == 2'(k))) mem[addr] <= pixel_data_in;
      if (wsel != 2'(k))            q         <= mem[addr];
    end

    assign rd_data[k] = q;
  end

  logic [1:0]       sel_q;
  logic [10:0]      h_q;
  logic [9:0]       v_q;
  logic             valid_q;
  logic [2:0][15:0] mapped;

  // RAM select follows the read data by one stage so the row mapping lines up.
  always_comb begin
    mapped    = '0;
    mapped[0] = rd_data[sel_q + 2'd1];
    mapped[1] = rd_data[sel_q + 2'd2];
    mapped[2] = rd_data[sel_q + 2'd3];
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sel_q           <= '0;
      h_q             <= '0;
      v_q             <= '0;
      valid_q         <= 1'b0;
      line_buffer_out <= '0;
      hcount_out      <= '0;
      vcount_out      <= '0;
      data_valid_out  <= 1'b0;
    end else begin
      sel_q          <= wsel;
      h_q            <= hcount_in;
      v_q            <= vrow;
      valid_q        <= wr_en;
      hcount_out     <= h_q;
      vcount_out     <= v_q;
      data_valid_out <= valid_q;
`ifdef BUFFER_OUT_ZERO_EN
      line_buffer_out <= valid_q ? mapped : '0;
`else
      line_buffer_out <= mapped;
`endif
    end
  end

endmodule

// File: tb/tb_buffer.sv
// Scoreboard bench for buffer: driver queues expected outputs, negedge monitor pairs them by cycle.
module tb_buffer;

  logic             clk_in = 1'b0;
  logic             rst_in = 1'b0;
  logic [10:0]      hcount_in = '0;
  logic [9:0]       vcount_in = '0;
  logic [15:0]      pixel_data_in = '0;
  logic             data_valid_in = 1'b0;
  logic [2:0][15:0] line_buffer_out;
  logic [10:0]      hcount_out;
  logic [9:0]       vcount_out;
  logic             data_valid_out;

  buffer #(.HRES(320), .VRES(240)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .pixel_data_in  (pixel_data_in),
    .data_valid_in  (data_valid_in),
    .line_buffer_out(line_buffer_out),
    .hcount_out     (hcount_out),
    .vcount_out     (vcount_out),
    .data_valid_out (data_valid_out)
  );

  always #5 clk_in = ~clk_in;

  int unsigned cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    bit          chk;
    logic [47:0] lb;
    logic [10:0] h;
    logic [9:0]  v;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

`ifdef BUFFER_OUT_ZERO_EN
  localparam logic [47:0] STALE = '0;
`else
  localparam logic [47:0] STALE = {3{16'd123}};
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [15:0] pat(input int r, input int c);
    return {8'(r), 8'(c)};
  endfunction

  task automatic drive(input int h, input int v, input logic [15:0] pix, input bit valid,
                       input bit chk, input logic [47:0] lb);
    exp_t e;
    @(posedge clk_in);
    #1;
    hcount_in     = 11'(h);
    vcount_in     = 10'(v);
    pixel_data_in = pix;
    data_valid_in = valid;
    if (valid && h < 320 && v < 240) begin
      e.cyc = cyc + 2;
      e.chk = chk;
      e.lb  = lb;
      e.h   = 11'(h);
      e.v   = (v >= 2) ? 10'(v - 2) : 10'(v + 238);
      sb.push_back(e);
    end
  endtask

  // Monitor: expectations whose cycle has passed are missing outputs.
  always @(negedge clk_in) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missing_output: got none by cycle %0d, required at cycle %0d (h=%0d v=%0d)",
               cyc, e.cyc, e.h, e.v);
    end
    if (data_valid_out === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got data_valid_out=1 at cycle %0d (h=%0d v=%0d), required 0",
                 cyc, hcount_out, vcount_out);
      end else begin
        e = sb.pop_front();
        check("out_cycle", 64'(cyc), 64'(e.cyc));
        check("hcount_out", 64'(hcount_out), 64'(e.h));
        check("vcount_out", 64'(vcount_out), 64'(e.v));
        if (e.chk) check("line_buffer_out", 64'(line_buffer_out), 64'(e.lb));
      end
    end
  end

  initial begin
    #1;
    check("reset_lb", 64'(line_buffer_out), 64'(0));
    check("reset_hcount", 64'(hcount_out), 64'(0));
    check("reset_vcount", 64'(vcount_out), 64'(0));
    check("reset_valid", 64'(data_valid_out), 64'(0));
    @(posedge clk_in);
    @(posedge clk_in);
    #3 rst_in = 1'b1;

    // Tiny image, pixel = {row, col}; row 3 sees rows 0,1,2 above it.
    for (int v = 0; v < 4; v++)
      for (int h = 0; h < 10; h++)
        drive(h, v, pat(v, h), 1'b1, v == 3, {pat(2, h), pat(1, h), pat(0, h)});
    drive(0, 0, 16'h0, 1'b0, 1'b0, '0);

    // Mid-line reset: in-flight outputs are discarded, row 4 is replayed afterwards.
    for (int h = 0; h < 4; h++)
      drive(h, 4, pat(4, h), 1'b1, 1'b1, {pat(3, h), pat(2, h), pat(1, h)});
    #2;
    rst_in = 1'b0;
    sb.delete();
    data_valid_in = 1'b0;
    #1;
    check("rst_async_lb", 64'(line_buffer_out), 64'(0));
    check("rst_async_hcount", 64'(hcount_out), 64'(0));
    check("rst_async_vcount", 64'(vcount_out), 64'(0));
    check("rst_async_valid", 64'(data_valid_out), 64'(0));
    @(posedge clk_in);
    #3 rst_in = 1'b1;
    for (int h = 0; h < 10; h++)
      drive(h, 4, pat(4, h), 1'b1, 1'b1, {pat(3, h), pat(2, h), pat(1, h)});

    // Constant 123 over full-width rows 0..5; data checked from row 3.
    for (int v = 0; v < 6; v++)
      for (int h = 0; h < 320; h++)
        drive(h, v, 16'd123, 1'b1, v >= 3, {3{16'd123}});

    // Out-of-range coordinates must never raise data_valid_out.
    drive(320, 5, 16'd555, 1'b1, 1'b0, '0);
    drive(1000, 5, 16'd555, 1'b1, 1'b0, '0);
    drive(0, 240, 16'd555, 1'b1, 1'b0, '0);

    // Invalid frame of 555: RAMs untouched, outputs show stale 123 (or zero when gated).
    for (int v = 0; v < 4; v++)
      for (int h = 0; h < 10; h++) begin
        drive(h, v, 16'd555, 1'b0, 1'b0, '0);
        if (v * 10 + h >= 2) begin
          #3;
          check("stale_lb", 64'(line_buffer_out), 64'(STALE));
          check("stale_valid", 64'(data_valid_out), 64'(0));
        end
      end

    // Following frame row 0 reads the older RAMs: must be 123, never 555.
    for (int h = 0; h < 10; h++)
      drive(h, 0, 16'd7, 1'b1, 1'b1, {3{16'd123}});

    drive(0, 0, 16'h0, 1'b0, 1'b0, '0);
    repeat (4) @(posedge clk_in);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/buffer.md
BUFFER -- requirements
Module: buffer

Interface
REQ-001 Parameter HRES, default 320: pixels per line; the line RAM depth.
REQ-002 Parameter VRES, default 240: lines per frame; SHALL be a multiple of 4.
REQ-003 clk_in  input  1  sole clock; all logic is rising-edge.
REQ-004 rst_in  input  1  reset, asynchronous assert, active-low.
REQ-005 hcount_in  input  11  column of pixel_data_in.
REQ-006 vcount_in  input  10  row of pixel_data_in.
REQ-007 pixel_data_in  input  16  pixel value, RGB565.
REQ-008 data_valid_in  input  1  qualifies the input pixel.
REQ-009 line_buffer_out  output  [2:0][16] (packed 2-D)  three vertically adjacent pixels; [0]=top (oldest), [1]=middle, [2]=bottom (newest).
REQ-010 hcount_out  output  11  column of line_buffer_out.
REQ-011 vcount_out  output  10  row of line_buffer_out[1].
REQ-012 data_valid_out  output  1  qualifies the outputs.

Function
REQ-013 The block SHALL hold four line RAMs, each HRES x 16 bits, with one registered read port and one write port each.
REQ-014 Write select SHALL be w = vcount_in[1:0].
- When data_valid_in=1, hcount_in<HRES and vcount_in<VRES: pixel_data_in is written to RAM w at address hcount_in.
- Otherwise no RAM is written.
REQ-015 Every cycle, the three RAMs other than RAM w SHALL be read at address hcount_in, independent of data_valid_in.
REQ-016 Output mapping: line_buffer_out[0] comes from RAM (w+1)%4 (row v-3), [1] from RAM (w+2)%4 (row v-2), [2] from RAM (w+3)%4 (row v-1).
REQ-017 Read-to-output latency SHALL be exactly 2 cycles: one cycle of RAM read, one output register.
- The RAM select used for output mapping SHALL be pipelined to match that latency.
REQ-018 hcount_out SHALL be hcount_in delayed 2 cycles.
REQ-019 vcount_out SHALL be (vcount_in - 2) mod VRES, delayed 2 cycles.
- vcount_in=0 gives VRES-2; vcount_in=1 gives VRES-1.
REQ-020 data_valid_out SHALL be data_valid_in delayed 2 cycles.
- data_valid_out SHALL be forced low for any input with hcount_in>=HRES or vcount_in>=VRES.
REQ-021 No read/write collision can occur: the RAM being written is never read in the same cycle.
REQ-022 Rows written while data_valid_in=0 SHALL leave RAM contents unchanged.
- Outputs still emit stale RAM contents, with data_valid_out=0.
REQ-023 The block SHALL hold no frame-level state.
- A vcount_in wrap from VRES-1 to 0 needs no special handling.
- Rows above the first three of a frame emit data left over from the previous frame.

Reset
REQ-024 On rst_in=0, all pipeline registers SHALL clear asynchronously: line_buffer_out=0, hcount_out=0, vcount_out=0, data_valid_out=0.
REQ-025 RAM contents SHALL NOT be reset.
REQ-026 Reset asserted mid-line SHALL discard in-flight pipeline data.
- Output resumes 2 cycles after the first valid input following release.

Configuration
REQ-027 Macro BUFFER_OUT_ZERO_EN:
- When defined, line_buffer_out SHALL read all-zero in every cycle where data_valid_out=0.
- When undefined, line_buffer_out shows raw RAM data regardless of data_valid_out.

Verification
REQ-028 Full frame, 320x240, pixel=123, valid=1, continuous. From frame row 3 onward, every output has line_buffer_out={123,123,123} and data_valid_out=1, 2 cycles after input.
- At input (v=3,h=0): outputs hcount_out=0, vcount_out=1.
REQ-029 Tiny image, 4 rows x 10 columns, pixel=555, valid=0. data_valid_out stays 0 throughout, and no RAM location reads back 555 in the following frame.
REQ-030 Tiny image, 4x10, pixel={8'(row),8'(col)}, valid=1. At input (v=3,h=5), 2 cycles later: line_buffer_out[0]=0x0005, [1]=0x0105, [2]=0x0205, hcount_out=5, vcount_out=1, data_valid_out=1.
REQ-031 Wrap check: input at v=0,h=7 -> vcount_out=238 and hcount_out=7, 2 cycles later. Input at v=1 -> vcount_out=239.
REQ-032 Apply rst_in=0 for one cycle mid-stream. All outputs read 0 immediately, before the next clock edge. Valid output reappears exactly 2 cycles after valid input resumes.
REQ-033 With BUFFER_OUT_ZERO_EN defined, repeat REQ-029: line_buffer_out=0 in every cycle. Without the macro, outputs show stale RAM data.
